// File: rtl/block_freq_tester.sv
// Streaming randomness checker: monobit |2*ones - N| over a 2**N_LOG2-bit run plus a
// per-block frequency test over 2**M_LOG2-bit blocks, with results held until the next start.
module block_freq_tester #(
    parameter int N_LOG2       = 7,
    parameter int M_LOG2       = 3,
    parameter int BLK_THRESH   = 4,
    parameter int MAX_BLK_FAIL = 2
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     ena,
    input  logic                     start,
    input  logic                     bit_valid,
    input  logic                     bit_in,
    input  logic [N_LOG2:0]          threshold,
    output logic                     busy,
    output logic                     done,
    output logic                     pass_mono,
    output logic                     pass_blk,
    output logic [N_LOG2:0]          s_abs,
    output logic [N_LOG2-M_LOG2:0]   blk_fail_cnt
);

    localparam int FW = N_LOG2 - M_LOG2 + 1;

    localparam logic [N_LOG2:0] N_W    = {1'b1, {N_LOG2{1'b0}}};
    localparam logic [N_LOG2:0] N_HALF = {2'b01, {(N_LOG2-1){1'b0}}};
    localparam logic [M_LOG2:0] M_W    = {1'b1, {M_LOG2{1'b0}}};
    localparam logic [M_LOG2:0] M_HALF = {2'b01, {(M_LOG2-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t              state;
    logic [N_LOG2:0]     ones;
    logic [N_LOG2:0]     thr_q;
    logic [N_LOG2-1:0]   bit_cnt;
    logic [M_LOG2:0]     blk_ones;

    logic                accept;
    logic                blk_end;
    logic                last_bit;
    logic                blk_fail;
    logic [N_LOG2:0]     ones_nxt;
    logic [M_LOG2:0]     blk_nxt;
    logic [M_LOG2:0]     blk_dev;
    logic [FW-1:0]       fail_nxt;
    logic [N_LOG2:0]     s_abs_nxt;

    // Deviations are formed in the counter's own width: 2*x - N is exact modulo 2**(N_LOG2+1)
    // because the true result always lies in [0, N].
    always_comb begin
        accept    = ena & bit_valid & ~start & (state == RUN);
        blk_end   = &bit_cnt[M_LOG2-1:0];
        last_bit  = &bit_cnt;
        ones_nxt  = ones + (N_LOG2+1)'(bit_in);
        blk_nxt   = blk_ones + (M_LOG2+1)'(bit_in);
        blk_dev   = (blk_nxt >= M_HALF) ? (blk_nxt + blk_nxt - M_W) : (M_W - blk_nxt - blk_nxt);
        blk_fail  = blk_end && (int'(blk_dev) > BLK_THRESH);
        fail_nxt  = blk_fail_cnt + FW'(blk_fail);
        s_abs_nxt = (ones_nxt >= N_HALF) ? (ones_nxt + ones_nxt - N_W) : (N_W - ones_nxt - ones_nxt);
    end

    // start is honoured from any state and wins over a bit presented in the same cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            ones         <= '0;
            thr_q        <= '0;
            bit_cnt      <= '0;
            blk_ones     <= '0;
            blk_fail_cnt <= '0;
            busy         <= 1'b0;
            done         <= 1'b0;
            pass_mono    <= 1'b0;
            pass_blk     <= 1'b0;
            s_abs        <= '0;
        end else if (ena) begin
            if (start) begin
                state        <= RUN;
                ones         <= '0;
                thr_q        <= threshold;
                bit_cnt      <= '0;
                blk_ones     <= '0;
                blk_fail_cnt <= '0;
                busy         <= 1'b1;
                done         <= 1'b0;
                pass_mono    <= 1'b0;
                pass_blk     <= 1'b0;
                s_abs        <= '0;
            end else if (accept) begin
                bit_cnt      <= bit_cnt + N_LOG2'(1);
                ones         <= ones_nxt;
                blk_ones     <= blk_end ? '0 : blk_nxt;
                blk_fail_cnt <= fail_nxt;
                if (last_bit) begin
                    state     <= DONE;
                    busy      <= 1'b0;
                    done      <= 1'b1;
                    s_abs     <= s_abs_nxt;
                    pass_mono <= (s_abs_nxt <= thr_q);
                    pass_blk  <= (int'(fail_nxt) <= MAX_BLK_FAIL);
                end
            end
        end
    end

endmodule

// File: tb/tb_block_freq_tester.sv
// Randomised bench for block_freq_tester: streams are scored by a plain-arithmetic
// reference model over the list of accepted bits.
module tb_block_freq_tester;

    localparam int N_LOG2       = 7;
    localparam int M_LOG2       = 3;
    localparam int BLK_THRESH   = 4;
    localparam int MAX_BLK_FAIL = 2;
    localparam int N = 1 << N_LOG2;
    localparam int M = 1 << M_LOG2;

    logic                   clk = 1'b0;
    logic                   rst_n;
    logic                   ena;
    logic                   start;
    logic                   bit_valid;
    logic                   bit_in;
    logic [N_LOG2:0]        threshold;
    logic                   busy;
    logic                   done;
    logic                   pass_mono;
    logic                   pass_blk;
    logic [N_LOG2:0]        s_abs;
    logic [N_LOG2-M_LOG2:0] blk_fail_cnt;

    int assertCount = 0;
    int failCount   = 0;
    bit stream[$];
    int expS, expFail, expMono, expBlk;

    block_freq_tester #(
        .N_LOG2(N_LOG2), .M_LOG2(M_LOG2), .BLK_THRESH(BLK_THRESH), .MAX_BLK_FAIL(MAX_BLK_FAIL)
    ) dut (
        .clk(clk), .rst_n(rst_n), .ena(ena), .start(start), .bit_valid(bit_valid),
        .bit_in(bit_in), .threshold(threshold), .busy(busy), .done(done),
        .pass_mono(pass_mono), .pass_blk(pass_blk), .s_abs(s_abs), .blk_fail_cnt(blk_fail_cnt)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input int observed, input int expected);
        assertCount++;
        if (observed !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference: count ones over the whole run and per block straight from the statistic's definition.
    task automatic runModel(input int thr);
        int total, c, d;
        total   = 0;
        expFail = 0;
        foreach (stream[i]) total += int'(stream[i]);
        expS = 2 * total - N;
        if (expS < 0) expS = -expS;
        for (int b = 0; b < N / M; b++) begin
            c = 0;
            for (int k = 0; k < M; k++) c += int'(stream[b * M + k]);
            d = 2 * c - M;
            if (d < 0) d = -d;
            if (d > BLK_THRESH) expFail++;
        end
        expMono = (expS <= thr) ? 1 : 0;
        expBlk  = (expFail <= MAX_BLK_FAIL) ? 1 : 0;
    endtask

    task automatic checkIdleOutputs(input string tag);
        checkOutput({tag, ":busy"}, busy, 0);
        checkOutput({tag, ":done"}, done, 0);
        checkOutput({tag, ":pass_mono"}, pass_mono, 0);
        checkOutput({tag, ":pass_blk"}, pass_blk, 0);
        checkOutput({tag, ":s_abs"}, s_abs, 0);
        checkOutput({tag, ":blk_fail_cnt"}, blk_fail_cnt, 0);
    endtask

    // Starts a run (with a bit offered in the start cycle that must be dropped), then feeds
    // nBits of stream with optional random gaps and a 10-cycle ena-low window mid-run.
    task automatic applyStimulus(input string tag, input int thr, input int nBits,
                                 input int gapMax, input bit pause);
        start     = 1'b1;
        threshold = (N_LOG2+1)'(thr);
        bit_valid = 1'b1;
        bit_in    = 1'b1;
        tick();
        start     = 1'b0;
        threshold = (N_LOG2+1)'($urandom_range(0, 255));
        checkOutput({tag, ":busy_after_start"}, busy, 1);
        checkOutput({tag, ":done_after_start"}, done, 0);
        for (int i = 0; i < nBits; i++) begin
            repeat ($urandom_range(0, gapMax)) begin
                bit_valid = 1'b0;
                bit_in    = 1'($urandom);
                tick();
            end
            if (pause && i == N / 2) begin
                ena = 1'b0;
                for (int k = 0; k < 10; k++) begin
                    bit_valid = 1'b1;
                    bit_in    = 1'($urandom);
                    start     = (k == 5);
                    tick();
                end
                start = 1'b0;
                ena   = 1'b1;
            end
            bit_valid = 1'b1;
            bit_in    = stream[i];
            threshold = (N_LOG2+1)'($urandom_range(0, 255));
            tick();
            if (i == N - 2) checkOutput({tag, ":done_before_last"}, done, 0);
            if (i == N - 1) checkOutput({tag, ":done_on_last"}, done, 1);
        end
        bit_valid = 1'b0;
    endtask

    task automatic checkResults(input string tag, input int thr);
        runModel(thr);
        checkOutput({tag, ":busy"}, busy, 0);
        checkOutput({tag, ":s_abs"}, s_abs, expS);
        checkOutput({tag, ":blk_fail_cnt"}, blk_fail_cnt, expFail);
        checkOutput({tag, ":pass_mono"}, pass_mono, expMono);
        checkOutput({tag, ":pass_blk"}, pass_blk, expBlk);
        repeat (3) begin
            bit_valid = 1'b1;
            bit_in    = 1'($urandom);
            tick();
        end
        bit_valid = 1'b0;
        checkOutput({tag, ":done_held"}, done, 1);
        checkOutput({tag, ":s_abs_held"}, s_abs, expS);
        checkOutput({tag, ":fail_held"}, blk_fail_cnt, expFail);
    endtask

    task automatic buildAlt();
        stream.delete();
        for (int i = 0; i < N; i++) stream.push_back(bit'(~i[0]));
    endtask

    task automatic buildSplit(input int nOnes);
        stream.delete();
        for (int i = 0; i < N; i++) stream.push_back(i < nOnes);
    endtask

    task automatic buildRandom();
        stream.delete();
        for (int i = 0; i < N; i++) stream.push_back(1'($urandom));
    endtask

    initial begin
        rst_n     = 1'b0;
        ena       = 1'b1;
        start     = 1'b0;
        bit_valid = 1'b0;
        bit_in    = 1'b0;
        threshold = '0;
        #12;
        checkIdleOutputs("reset");
        tick();
        rst_n = 1'b1;
        tick();

        buildAlt();
        applyStimulus("t1_alt", 16, N, 0, 1'b0);
        checkResults("t1_alt", 16);

        buildSplit(N);
        applyStimulus("t2_ones", 16, N, 0, 1'b0);
        checkResults("t2_ones", 16);

        buildSplit(N / 2);
        applyStimulus("t3_half", 16, N, 0, 1'b0);
        checkResults("t3_half", 16);

        buildAlt();
        applyStimulus("t4_gaps", 16, N, 3, 1'b1);
        checkResults("t4_gaps", 16);

        buildRandom();
        applyStimulus("t5_partial", 40, 50, 1, 1'b0);
        checkOutput("t5_partial:busy", busy, 1);
        buildAlt();
        applyStimulus("t5_restart", 16, N, 1, 1'b0);
        checkResults("t5_restart", 16);

        buildSplit(N);
        applyStimulus("t5_rst", 16, 30, 0, 1'b0);
        checkOutput("t5_rst:fail_before", blk_fail_cnt, 30 / M);
        checkOutput("t5_rst:busy_before", busy, 1);
        #2;
        rst_n = 1'b0;
        #1;
        checkIdleOutputs("t5_rst_async");
        #2;
        rst_n = 1'b1;
        repeat (5) begin
            bit_valid = 1'b1;
            bit_in    = 1'b1;
            tick();
        end
        bit_valid = 1'b0;
        checkIdleOutputs("t5_idle_ignores_bits");

        buildSplit(72);
        applyStimulus("t6_thr16", 16, N, 0, 1'b0);
        checkResults("t6_thr16", 16);
        applyStimulus("t6_thr15", 15, N, 1, 1'b0);
        checkResults("t6_thr15", 15);

        for (int r = 0; r < 4; r++) begin
            int thr;
            thr = $urandom_range(0, N);
            buildRandom();
            applyStimulus($sformatf("rand%0d", r), thr, N, 2, (r == 1));
            checkResults($sformatf("rand%0d", r), thr);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
